// File: rtl/pu_enc_pkg.sv
// Shared types and constants for the PU instruction encoder.
// Instruction classes, field widths, op/flag/li-op codes and the descriptor payload.
package pu_enc_pkg;

  localparam int unsigned INSN_W  = 16;
  localparam int unsigned CLS_W   = 5;
  localparam int unsigned REG_W   = 2;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned FF_W    = 2;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned NUM_CLS = 20;

  typedef enum logic [CLS_W-1:0] {
    CLS_NOP    = 5'd0,
    CLS_HALT   = 5'd1,
    CLS_CAL_RR = 5'd2,
    CLS_EVA    = 5'd3,
    CLS_JP_RR  = 5'd4,
    CLS_SM_RR  = 5'd5,
    CLS_LM_RR  = 5'd6,
    CLS_CAL_RI = 5'd7,
    CLS_JP_I   = 5'd8,
    CLS_SM_I   = 5'd9,
    CLS_JP_PC  = 5'd10,
    CLS_JP_RA  = 5'd11,
    CLS_LI_SM  = 5'd12,
    CLS_LI     = 5'd13,
    CLS_LIL    = 5'd14,
    CLS_LIH    = 5'd15,
    CLS_LM_I   = 5'd16,
    CLS_LM_RI  = 5'd17,
    CLS_SM_RI  = 5'd18,
    CLS_CMP_I  = 5'd19
  } cls_e;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_XOR = 3'd7;

  localparam logic [FF_W-1:0] FF_UC = 2'd0;
  localparam logic [FF_W-1:0] FF_ZE = 2'd1;
  localparam logic [FF_W-1:0] FF_CA = 2'd2;
  localparam logic [FF_W-1:0] FF_SG = 2'd3;

  localparam logic [1:0] LIOP_SM  = 2'd0;
  localparam logic [1:0] LIOP_LI  = 2'd1;
  localparam logic [1:0] LIOP_LIL = 2'd2;
  localparam logic [1:0] LIOP_LIH = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [CLS_W-1:0] cls;
    logic [REG_W-1:0] rw;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [OP_W-1:0]  op;
    logic             f;
    logic             p;
    logic             sub;
    logic [FF_W-1:0]  ff;
    logic [IMM_W-1:0] imm;
  } desc_t;

  function automatic logic is_reserved(input logic [CLS_W-1:0] c);
    return c >= CLS_W'(NUM_CLS);
  endfunction

endpackage

// File: rtl/insn_pack.sv
// Combinational descriptor -> 16-bit PU instruction word table.
// Unused bits of every format are driven to zero; unknown classes give NOP.
module insn_pack
  import pu_enc_pkg::*;
(
  input  desc_t             d,
  output logic [INSN_W-1:0] word_c
);

  always_comb begin
    word_c = '0;
    case (d.cls)
      CLS_NOP:    word_c = 16'h0000;
      CLS_HALT:   word_c = 16'h0001;
      CLS_CAL_RR: word_c = {6'b000010, d.rw, d.f, d.op, d.ra, d.rb};
      CLS_EVA:    word_c = {6'b000011, 3'b000, d.op, d.ra, d.rb};
      CLS_JP_RR:  word_c = {6'b000100, d.ff, d.p, d.op, d.ra, d.rb};
      CLS_SM_RR:  word_c = {6'b000110, d.f, 2'b00, d.op, d.ra, d.rb};
      CLS_LM_RR:  word_c = {6'b000111, d.rw, d.f, d.op, d.ra, d.rb};
      CLS_CAL_RI: word_c = {3'b001, d.sub, d.rw, d.ra, d.imm};
      CLS_JP_I:   word_c = {3'b010, d.p, 2'b00, d.ff, d.imm};
      CLS_SM_I:   word_c = {3'b010, 1'b0, 2'b10, d.rb, d.imm};
      CLS_JP_PC:  word_c = {3'b010, d.p, 2'b11, d.ff, d.imm};
      CLS_JP_RA:  word_c = {3'b011, d.p, d.ra, d.ff, d.imm};
      CLS_LI_SM:  word_c = {4'b1000, d.rw, LIOP_SM, 8'h00};
      CLS_LI:     word_c = {4'b1000, d.rw, LIOP_LI, d.imm};
      CLS_LIL:    word_c = {4'b1000, d.rw, LIOP_LIL, d.imm};
      CLS_LIH:    word_c = {4'b1000, d.rw, LIOP_LIH, d.imm};
      CLS_LM_I:   word_c = {4'b1001, d.rw, 2'b00, d.imm};
      CLS_LM_RI:  word_c = {4'b1010, d.rw, d.ra, d.imm};
      CLS_SM_RI:  word_c = {4'b1011, d.ra, d.rb, d.imm};
      CLS_CMP_I:  word_c = {4'b1111, d.ra, 2'b00, d.imm};
      default:    word_c = '0;
    endcase
  end

endmodule

// File: rtl/insn_enc.sv
// Streaming instruction encoder: packs descriptors into PU words and writes them to imem.
// Define INSN_ENC_CHECK_EN to drop reserved classes and flag them on the sticky err port.
module insn_enc
  import pu_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CLS_W-1:0]  cls,
  input  logic [REG_W-1:0]  rw,
  input  logic [REG_W-1:0]  ra,
  input  logic [REG_W-1:0]  rb,
  input  logic [OP_W-1:0]   op,
  input  logic              f,
  input  logic              p,
  input  logic              sub,
  input  logic [FF_W-1:0]   ff,
  input  logic [IMM_W-1:0]  imm,
  output logic              iwe,
  output logic [ADDR_W-1:0] iad,
  output logic [INSN_W-1:0] iwd,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W-1:0] cnt
`ifdef INSN_ENC_CHECK_EN
  ,
  output logic              err
`endif
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                last_q;
  desc_t               desc_c;
  logic [INSN_W-1:0]   word_c;
  logic                accept_c, rsvd_c, wr_c, launch_c;

  always_comb begin
    desc_c     = '0;
    desc_c.cls = cls;
    desc_c.rw  = rw;
    desc_c.ra  = ra;
    desc_c.rb  = rb;
    desc_c.op  = op;
    desc_c.f   = f;
    desc_c.p   = p;
    desc_c.sub = sub;
    desc_c.ff  = ff;
    desc_c.imm = imm;
  end

  insn_pack u_pack (
    .d      (desc_c),
    .word_c (word_c)
  );

`ifdef INSN_ENC_CHECK_EN
  assign rsvd_c = is_reserved(cls);
`else
  assign rsvd_c = 1'b0;
`endif

  assign accept_c = in_valid & in_ready;
  assign wr_c     = accept_c & ~rsvd_c;
  assign launch_c = start & (state_q != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Session ends the cycle after its final word (HALT or top address) is written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_RUN;
      ST_RUN:  if (last_q) state_d = ST_DONE;
      ST_DONE: if (start)  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = ~last_q;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // cnt trails the write strobe so that iad == base + cnt while iwe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iwe    <= 1'b0;
      iad    <= '0;
      iwd    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      addr_q <= '0;
      last_q <= 1'b0;
`ifdef INSN_ENC_CHECK_EN
      err    <= 1'b0;
`endif
    end else begin
      iwe <= wr_c;
      if (launch_c) begin
        addr_q <= base;
        cnt    <= '0;
        ovf    <= 1'b0;
        last_q <= 1'b0;
`ifdef INSN_ENC_CHECK_EN
        err    <= 1'b0;
`endif
      end else begin
        if (iwe) cnt <= cnt + ADDR_W'(1);
        if (wr_c) begin
          iad    <= addr_q;
          iwd    <= word_c;
          addr_q <= addr_q + ADDR_W'(1);
          last_q <= (cls == CLS_HALT) || (addr_q == {ADDR_W{1'b1}});
        end
        if ((state_q == ST_RUN) && last_q) begin
          last_q <= 1'b0;
          ovf    <= (iad == {ADDR_W{1'b1}});
        end
`ifdef INSN_ENC_CHECK_EN
        if (accept_c && rsvd_c) err <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_insn_enc.sv
// Self-checking bench for insn_enc: directed cases with literal expectations plus
// randomized sessions checked every cycle against a transaction-level reference model.
module tb_insn_enc;

  localparam int unsigned ADDR_W = 8;
  localparam int MAXA = (1 << ADDR_W) - 1;
`ifdef INSN_ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [4:0]        cls = '0;
  logic [1:0]        rw = '0, ra = '0, rb = '0, ff = '0;
  logic [2:0]        op = '0;
  logic              f = 1'b0, p = 1'b0, sub = 1'b0;
  logic [7:0]        imm = '0;
  logic              iwe, busy, done, ovf;
  logic [ADDR_W-1:0] iad, cnt;
  logic [15:0]       iwd;
`ifdef INSN_ENC_CHECK_EN
  logic              err;
`endif

  int checks = 0;
  int errors = 0;

  insn_enc #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base),
    .in_valid(in_valid), .in_ready(in_ready),
    .cls(cls), .rw(rw), .ra(ra), .rb(rb), .op(op),
    .f(f), .p(p), .sub(sub), .ff(ff), .imm(imm),
    .iwe(iwe), .iad(iad), .iwd(iwd),
    .busy(busy), .done(done), .ovf(ovf), .cnt(cnt)
`ifdef INSN_ENC_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction word from the format tables, as field weights.
  function automatic int enc(int c, int w_, int a_, int b_, int o_, int f_, int p_,
                             int s_, int ff_, int i_);
    case (c)
      0:  return 0;
      1:  return 1;
      2:  return 'h0800 + w_*256 + f_*128 + o_*16 + a_*4 + b_;
      3:  return 'h0C00 + o_*16 + a_*4 + b_;
      4:  return 'h1000 + ff_*256 + p_*128 + o_*16 + a_*4 + b_;
      5:  return 'h1800 + f_*512 + o_*16 + a_*4 + b_;
      6:  return 'h1C00 + w_*256 + f_*128 + o_*16 + a_*4 + b_;
      7:  return 'h2000 + s_*'h1000 + w_*'h400 + a_*'h100 + i_;
      8:  return 'h4000 + p_*'h1000 + ff_*'h100 + i_;
      9:  return 'h4800 + b_*'h100 + i_;
      10: return 'h4C00 + p_*'h1000 + ff_*'h100 + i_;
      11: return 'h6000 + p_*'h1000 + a_*'h400 + ff_*'h100 + i_;
      12: return 'h8000 + w_*'h400;
      13: return 'h8100 + w_*'h400 + i_;
      14: return 'h8200 + w_*'h400 + i_;
      15: return 'h8300 + w_*'h400 + i_;
      16: return 'h9000 + w_*'h400 + i_;
      17: return 'hA000 + w_*'h400 + a_*'h100 + i_;
      18: return 'hB000 + a_*'h400 + b_*'h100 + i_;
      19: return 'hF000 + a_*'h400 + i_;
      default: return 0;
    endcase
  endfunction

  // Reference model: session flags, next address, words written, pending write.
  bit m_run, m_done, m_stop, m_ovf, m_err, m_iwe;
  int m_next, m_cnt, m_iad, m_iwd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_stop = 0; m_ovf = 0; m_err = 0; m_iwe = 0;
      m_next = 0; m_cnt = 0; m_iad = 0; m_iwd = 0;
    end else begin
      bit was_run, acc, wrote;
      was_run = m_run;
      acc     = in_valid && m_run && !m_stop;
      wrote   = 0;
      if (m_iwe) m_cnt++;
      if (m_run && m_stop) begin
        m_run = 0; m_done = 1; m_stop = 0; m_ovf = (m_iad == MAXA);
      end else if (acc) begin
        if (CHK && int'(cls) >= 20) m_err = 1;
        else begin
          wrote  = 1;
          m_iad  = m_next;
          m_iwd  = enc(int'(cls), int'(rw), int'(ra), int'(rb), int'(op), int'(f),
                       int'(p), int'(sub), int'(ff), int'(imm));
          m_next = m_next + 1;
          if (int'(cls) == 1 || m_iad == MAXA) m_stop = 1;
        end
      end
      if (start && !was_run) begin
        m_run = 1; m_done = 0; m_ovf = 0; m_err = 0; m_cnt = 0; m_stop = 0;
        m_next = int'(base);
      end
      m_iwe = wrote;
    end
  end

  always @(negedge clk) begin
    chk("iwe", 32'(iwe), 32'(m_iwe));
    chk("in_ready", 32'(in_ready), 32'(m_run && !m_stop));
    chk("busy", 32'(busy), 32'(m_run));
    chk("done", 32'(done), 32'(m_done));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("cnt", 32'(cnt), 32'(m_cnt & MAXA));
    if (m_iwe) begin
      chk("iad", 32'(iad), 32'(m_iad));
      chk("iwd", 32'(iwd), 32'(m_iwd));
    end
`ifdef INSN_ENC_CHECK_EN
    chk("err", 32'(err), 32'(m_err));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_desc(input int c, input int w_, input int a_, input int b_,
                          input int o_, input int f_, input int p_, input int s_,
                          input int ff_, input int i_);
    cls = 5'(c); rw = 2'(w_); ra = 2'(a_); rb = 2'(b_); op = 3'(o_);
    f = 1'(f_); p = 1'(p_); sub = 1'(s_); ff = 2'(ff_); imm = 8'(i_);
  endtask

  task automatic rand_desc();
    int r;
    r = $urandom_range(0, 11);
    if (r == 0)      cls = 5'd1;
    else if (r == 1) cls = 5'($urandom_range(20, 31));
    else             cls = 5'($urandom_range(0, 19));
    rw = 2'($urandom); ra = 2'($urandom); rb = 2'($urandom); op = 3'($urandom);
    f = 1'($urandom); p = 1'($urandom); sub = 1'($urandom); ff = 2'($urandom);
    imm = 8'($urandom);
  endtask

  task automatic begin_session(input int b);
    base = ADDR_W'(b);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_iwe", 32'(iwe), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    rst_n = 1'b1;
    tick();

    // Pending descriptor while idle is not taken
    set_desc(2, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    chk("idle_no_write", 32'(iwe), 0);
    in_valid = 1'b0;

    // CAL_RR rw=1 op=ADD ra=2 rb=3 at base 0, then HALT
    begin_session(0);
    set_desc(2, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    chk("calrr_iwe", 32'(iwe), 1);
    chk("calrr_iad", 32'(iad), 0);
    chk("calrr_iwd", 32'(iwd), 32'h090B);
    set_desc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    chk("halt_iwd", 32'(iwd), 32'h0001);
    chk("halt_in_ready", 32'(in_ready), 0);
    tick();
    chk("halt_done", 32'(done), 1);
    chk("halt_busy", 32'(busy), 0);
    chk("halt_cnt", 32'(cnt), 2);

    // LI then JP_PC back to back
    begin_session(0);
    set_desc(13, 2, 0, 0, 0, 0, 0, 0, 0, 'h5A);
    in_valid = 1'b1;
    tick();
    chk("li_iad", 32'(iad), 0);
    chk("li_iwd", 32'(iwd), 32'h895A);
    set_desc(10, 0, 0, 0, 0, 0, 0, 0, 1, 'hFE);
    tick();
    chk("jppc_iwe", 32'(iwe), 1);
    chk("jppc_iad", 32'(iad), 1);
    chk("jppc_iwd", 32'(iwd), 32'h4DFE);
    set_desc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    tick();

    // Three NOPs then HALT from base 0x10; a further descriptor stays refused
    begin_session('h10);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_desc((i == 3) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("nop_last_iad", 32'(iad), 32'h13);
    chk("nop_last_iwd", 32'(iwd), 32'h0001);
    set_desc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("nop_done", 32'(done), 1);
    chk("nop_in_ready", 32'(in_ready), 0);
    chk("nop_cnt", 32'(cnt), 4);
    in_valid = 1'b0;
    tick();

    // Address space exhaustion from base 0xFE
    begin_session(MAXA - 1);
    set_desc(3, 0, 1, 2, 5, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    tick();
    chk("wrap_last_iad", 32'(iad), 32'(MAXA));
    chk("wrap_in_ready", 32'(in_ready), 0);
    tick();
    chk("wrap_iwe", 32'(iwe), 0);
    chk("wrap_ovf", 32'(ovf), 1);
    chk("wrap_done", 32'(done), 1);
    in_valid = 1'b0;
    tick();

    // Reset during an active session
    begin_session(0);
    set_desc(2, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_iwe", 32'(iwe), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_cnt", 32'(cnt), 0);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reserved class
    begin_session(0);
    set_desc(25, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    tick();
`ifdef INSN_ENC_CHECK_EN
    chk("rsvd_no_write", 32'(iwe), 0);
    chk("rsvd_err", 32'(err), 1);
`else
    chk("rsvd_write", 32'(iwe), 1);
    chk("rsvd_iwd", 32'(iwd), 0);
`endif
    set_desc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    tick();

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      int b, guard;
      bit acc;
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(MAXA - 6, MAXA)
                                      : $urandom_range(0, MAXA);
      in_valid = 1'($urandom);
      rand_desc();
      tick();
      begin_session(b);
      in_valid = 1'b0;
      guard = 0;
      while (!done && guard < 400) begin
        acc = in_valid && in_ready;
        start = ($urandom_range(0, 15) == 0);
        tick();
        if (acc || !in_valid) begin
          in_valid = ($urandom_range(0, 3) != 0);
          rand_desc();
        end
        guard++;
      end
      start = 1'b0;
      chk("session_end", 32'(done), 1);
      in_valid = 1'b0;
      tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
